// File: rtl/flght_seq.sv
// flght_seq: flight sequencer (IDLE -> CAL -> RUN -> LAND -> IDLE) feeding flght_cntrl.
// Ramps thrust toward the commanded target and gates the motors.
// Optional feature: define WATCHDOG_EN to force LAND after a command-silence period in RUN.
module flght_seq #(
    parameter logic [15:0] RAMP_DIV  = 16'd50000,
    parameter logic [8:0]  RAMP_STEP = 9'd8,
    parameter logic [23:0] CAL_TMO   = 24'd5000000
`ifdef WATCHDOG_EN
    ,
    parameter logic [25:0] WD_CYCLES = 26'd50000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_cal,
    input  logic       cmd_thrst,
    input  logic [8:0] thrst_tgt_in,
    input  logic       cmd_land,
    input  logic       cal_done,
    output logic       inertial_cal,
    output logic       strt_cal,
    output logic [8:0] thrst,
    output logic       motors_off,
    output logic       cmd_ack,
    output logic       cmd_nak,
    output logic       cal_err,
    output logic       wd_trip
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2,
        LAND = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [8:0]  tgt, tgt_nx, thrst_nx;
    logic [15:0] presc, presc_nx;
    logic [23:0] cal_tmr, cal_tmr_nx;
    logic        ack_nx, nak_nx, strt_nx, cal_err_nx;
    logic        tick;
    logic [9:0]  up_sum, dn_lim;
    logic [8:0]  ramp_val;
    logic        any_strobe, win_land, win_cal, win_thrst;
    logic        wd_expire;

    // Strobe arbitration: land beats cal beats thrust
    always_comb begin
        any_strobe = cmd_cal | cmd_thrst | cmd_land;
        win_land   = cmd_land;
        win_cal    = cmd_cal & ~cmd_land;
        win_thrst  = cmd_thrst & ~cmd_cal & ~cmd_land;
    end

    // One ramp step toward the target, computed in 10 bits so it never wraps
    always_comb begin
        up_sum   = {1'b0, thrst} + {1'b0, RAMP_STEP};
        dn_lim   = {1'b0, tgt} + {1'b0, RAMP_STEP};
        ramp_val = thrst;
        if (thrst < tgt) begin
            ramp_val = (up_sum > {1'b0, tgt}) ? tgt : up_sum[8:0];
        end else if (thrst > tgt) begin
            ramp_val = ({1'b0, thrst} > dn_lim) ? 9'(thrst - RAMP_STEP) : tgt;
        end
    end

`ifdef WATCHDOG_EN
    logic [25:0] wd_cnt, wd_cnt_nx;
    logic        wd_trip_nx;

    // Command-silence counter, only running in RUN between strobes
    always_comb begin
        wd_expire = (state == RUN) && !any_strobe && (wd_cnt == 26'(WD_CYCLES - 26'd1));
        wd_cnt_nx = ((state == RUN) && !any_strobe && !wd_expire) ? 26'(wd_cnt + 26'd1) : '0;
    end

    // Watchdog counter and trip pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            wd_trip <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_nx;
            wd_trip <= wd_trip_nx;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign wd_trip   = 1'b0;
`endif

    // Next-state, target, thrust, timers and pulse outputs
    always_comb begin
        state_nx   = state;
        tgt_nx     = tgt;
        thrst_nx   = thrst;
        presc_nx   = '0;
        cal_tmr_nx = '0;
        ack_nx     = 1'b0;
        nak_nx     = 1'b0;
        strt_nx    = 1'b0;
        cal_err_nx = cal_err;
        tick       = 1'b0;
`ifdef WATCHDOG_EN
        wd_trip_nx = 1'b0;
`endif

        if (state == RUN || state == LAND) begin
            tick     = (presc == 16'(RAMP_DIV - 16'd1));
            presc_nx = tick ? '0 : 16'(presc + 16'd1);
            if (tick) begin
                thrst_nx = ramp_val;
            end
        end

        case (state)
            IDLE: begin
                thrst_nx = '0;
                tgt_nx   = '0;
                if (win_cal) begin
                    state_nx   = CAL;
                    ack_nx     = 1'b1;
                    strt_nx    = 1'b1;
                    cal_err_nx = 1'b0;
                end else if (any_strobe) begin
                    nak_nx = 1'b1;
                end
            end
            CAL: begin
                thrst_nx = '0;
                if (win_land) begin
                    state_nx = IDLE;
                    ack_nx   = 1'b1;
                end else begin
                    nak_nx = any_strobe;
                    if (cal_done) begin
                        state_nx = RUN;
                        tgt_nx   = '0;
                    end else if (cal_tmr == 24'(CAL_TMO - 24'd1)) begin
                        state_nx   = IDLE;
                        cal_err_nx = 1'b1;
                    end else begin
                        cal_tmr_nx = 24'(cal_tmr + 24'd1);
                    end
                end
            end
            RUN: begin
                if (win_land) begin
                    state_nx = LAND;
                    tgt_nx   = '0;
                    ack_nx   = 1'b1;
                end else if (win_cal) begin
                    nak_nx = 1'b1;
                end else if (win_thrst) begin
                    tgt_nx = thrst_tgt_in;
                    ack_nx = 1'b1;
                end else if (wd_expire) begin
                    state_nx = LAND;
                    tgt_nx   = '0;
`ifdef WATCHDOG_EN
                    wd_trip_nx = 1'b1;
`endif
                end
            end
            LAND: begin
                tgt_nx = '0;
                nak_nx = any_strobe;
                if (tick && thrst == 9'd0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx == IDLE) begin
            thrst_nx = '0;
            tgt_nx   = '0;
        end
    end

    // State and datapath registers; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tgt          <= '0;
            thrst        <= '0;
            presc        <= '0;
            cal_tmr      <= '0;
            cmd_ack      <= 1'b0;
            cmd_nak      <= 1'b0;
            strt_cal     <= 1'b0;
            cal_err      <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
        end else begin
            state        <= state_nx;
            tgt          <= tgt_nx;
            thrst        <= thrst_nx;
            presc        <= presc_nx;
            cal_tmr      <= cal_tmr_nx;
            cmd_ack      <= ack_nx;
            cmd_nak      <= nak_nx;
            strt_cal     <= strt_nx;
            cal_err      <= cal_err_nx;
            inertial_cal <= (state_nx == CAL);
            motors_off   <= (state_nx == IDLE);
        end
    end

endmodule
